// File: rtl/route_demux_ctrl.sv
// route_demux_ctrl
// ----------------
// A 2-entry in-order buffer that steers each message to one of p_noutputs
// ports. The port is chosen by the destination field held in the top
// $clog2(p_noutputs) bits of the message. A head message whose destination
// is outside 0..p_noutputs-1 is never offered on any port. It stays head for
// exactly one cycle, is then discarded, and drop_count counts it.
//
// Handshake: on every interface a transfer happens in a cycle where both
// valid and ready are high at the rising clk edge. valid never depends on
// ready. Once valid is high, it and its data hold steady until the transfer.
// recv_rdy depends only on the buffer state. There is no bypass when the
// buffer is full.
//
// Ports:
//   clk         sole clock, rising edge
//   reset       asynchronous, active-low reset
//   recv_msg    incoming message (p_nbits)
//   recv_val    recv_msg is valid
//   recv_rdy    buffer can accept a message this cycle
//   send_msg    flattened per-port messages, port i at [i*p_nbits +: p_nbits]
//   send_val    per-port valid (one-hot or zero)
//   send_rdy    per-port ready
//   drop_count  saturating count of discarded illegal-destination messages
//   occupancy   buffered message count; this is also the FSM state encoding
module route_demux_ctrl #(
  parameter int unsigned p_nbits    = 8,
  parameter int unsigned p_noutputs = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [p_nbits-1:0]              recv_msg,
  input  logic                            recv_val,
  output logic                            recv_rdy,
  output logic [p_noutputs*p_nbits-1:0]   send_msg,
  output logic [p_noutputs-1:0]           send_val,
  input  logic [p_noutputs-1:0]           send_rdy,
  output logic [7:0]                      drop_count,
  output logic [1:0]                      occupancy
);

  localparam int unsigned dest_w = $clog2(p_noutputs);
  localparam int unsigned dec_w  = 1 << dest_w;
  // One bit per encodable destination. A bit is set when that destination
  // is a real port. This avoids a magnitude compare, which would always be
  // true when p_noutputs is a power of two.
  localparam logic [dec_w-1:0] legal_mask = {dec_w{1'b1}} >> (dec_w - p_noutputs);

  typedef enum logic [1:0] {
    st_empty = 2'd0,
    st_one   = 2'd1,
    st_full  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [p_nbits-1:0] entry0;  // head of the buffer
  logic [p_nbits-1:0] entry1;  // second entry, valid only in st_full
  logic [dest_w-1:0]  head_dest;
  logic [dec_w-1:0]   dest_dec;
  logic               has_head, head_legal, head_sent, drop, enq, deq;

  assign head_dest = entry0[p_nbits-1 -: dest_w];
  assign occupancy = state;

  always_comb begin
    has_head   = (state != st_empty);
    head_legal = legal_mask[head_dest];
    dest_dec   = '0;
    dest_dec[head_dest] = 1'b1;

    // send_val and send_msg come only from registered state. Stale entry
    // contents are never shown, because the gating uses has_head.
    send_val = (has_head && head_legal) ? dest_dec[p_noutputs-1:0] : '0;
    send_msg = '0;
    for (int unsigned i = 0; i < p_noutputs; i++) begin
      if (send_val[i]) send_msg[i*p_nbits +: p_nbits] = entry0;
    end

    // Ready on a port that is not selected is masked out here.
    head_sent = |(send_val & send_rdy);
    drop      = has_head && !head_legal;
    deq       = head_sent || drop;
    recv_rdy  = (state != st_full);
    enq       = recv_val && recv_rdy;

    state_nxt = state;
    case (state)
      st_empty: if (enq) state_nxt = st_one;
      st_one: begin
        if (enq && !deq)      state_nxt = st_full;
        else if (!enq && deq) state_nxt = st_empty;
      end
      st_full:  if (deq) state_nxt = st_one;
      default:  state_nxt = st_empty;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= st_empty;
    else        state <= state_nxt;
  end

  // The head is always entry0. A dequeue from st_full shifts entry1 forward.
  // In st_one, an enqueue that happens together with a dequeue writes the
  // head directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      case (state)
        st_empty: if (enq) entry0 <= recv_msg;
        st_one: begin
          if (enq) begin
            if (deq) entry0 <= recv_msg;
            else     entry1 <= recv_msg;
          end
        end
        st_full:  if (deq) entry0 <= entry1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           drop_count <= 8'd0;
    else if (drop && drop_count != 8'hff) drop_count <= drop_count + 8'd1;
  end

endmodule

// File: tb/tb_route_demux_ctrl.sv
module tb_route_demux_ctrl;

  logic clk;
  logic reset;

  // DUT with 4 ports: every destination is legal
  logic [7:0]  recv_msg4;
  logic        recv_val4;
  logic        recv_rdy4;
  logic [31:0] send_msg4;
  logic [3:0]  send_val4;
  logic [3:0]  send_rdy4;
  logic [7:0]  drop_count4;
  logic [1:0]  occupancy4;

  // DUT with 3 ports: destination 3 is illegal
  logic [7:0]  recv_msg3;
  logic        recv_val3;
  logic        recv_rdy3;
  logic [23:0] send_msg3;
  logic [2:0]  send_val3;
  logic [2:0]  send_rdy3;
  logic [7:0]  drop_count3;
  logic [1:0]  occupancy3;

  route_demux_ctrl #(.p_nbits(8), .p_noutputs(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .recv_msg(recv_msg4), .recv_val(recv_val4), .recv_rdy(recv_rdy4),
    .send_msg(send_msg4), .send_val(send_val4), .send_rdy(send_rdy4),
    .drop_count(drop_count4), .occupancy(occupancy4)
  );

  route_demux_ctrl #(.p_nbits(8), .p_noutputs(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .recv_msg(recv_msg3), .recv_val(recv_val3), .recv_rdy(recv_rdy3),
    .send_msg(send_msg3), .send_val(send_val3), .send_rdy(send_rdy3),
    .drop_count(drop_count3), .occupancy(occupancy3)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard / checking ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge. Outputs are read
  // then too, well away from the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  msg;
    logic        val;
    logic [3:0]  rdy;
    logic [3:0]  e_sv;
    logic [31:0] e_msg;
    logic [1:0]  e_occ;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic [7:0] msg, logic val, logic [3:0] rdy,
                              logic [3:0] e_sv, logic [31:0] e_msg,
                              logic [1:0] e_occ, logic e_rdy);
    vec_t v;
    v.msg = msg; v.val = val; v.rdy = rdy;
    v.e_sv = e_sv; v.e_msg = e_msg; v.e_occ = e_occ; v.e_rdy = e_rdy;
    return v;
  endfunction

  logic [7:0]  m, h;
  logic [3:0]  exp_sv;
  logic [31:0] exp_msg;

  initial begin
    // Expected outputs describe the cycle before the clock edge that
    // consumes the inputs.
    // Basic route: 0x85 (dest 2) is accepted on the first edge after reset.
    vecs[0]  = mk(8'h85, 1'b1, 4'b0000, 4'b0000, 32'h0000_0000, 2'd0, 1'b1);
    vecs[1]  = mk(8'h00, 1'b0, 4'b1111, 4'b0100, 32'h0085_0000, 2'd1, 1'b1);
    vecs[2]  = mk(8'h00, 1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 2'd0, 1'b1);
    // Backpressure: 0x05, 0x46 fill the buffer, and 0xC7 is refused while full.
    vecs[3]  = mk(8'h05, 1'b1, 4'b0000, 4'b0000, 32'h0000_0000, 2'd0, 1'b1);
    vecs[4]  = mk(8'h46, 1'b1, 4'b0000, 4'b0001, 32'h0000_0005, 2'd1, 1'b1);
    vecs[5]  = mk(8'hC7, 1'b1, 4'b0000, 4'b0001, 32'h0000_0005, 2'd2, 1'b0);
    vecs[6]  = mk(8'hC7, 1'b1, 4'b0000, 4'b0001, 32'h0000_0005, 2'd2, 1'b0);
    vecs[7]  = mk(8'hC7, 1'b1, 4'b0001, 4'b0001, 32'h0000_0005, 2'd2, 1'b0);
    // Head 0x46 on port 1. Other ports are ready, but port 1 is not.
    vecs[8]  = mk(8'hC7, 1'b1, 4'b1101, 4'b0010, 32'h0000_4600, 2'd1, 1'b1);
    vecs[9]  = mk(8'h00, 1'b0, 4'b0010, 4'b0010, 32'h0000_4600, 2'd2, 1'b0);
    vecs[10] = mk(8'h00, 1'b0, 4'b1111, 4'b1000, 32'hC700_0000, 2'd1, 1'b1);
    vecs[11] = mk(8'h00, 1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 2'd0, 1'b1);

    reset = 1'b0;
    recv_msg4 = '0; recv_val4 = 1'b0; send_rdy4 = '0;
    recv_msg3 = '0; recv_val3 = 1'b0; send_rdy3 = '0;

    // Reset values, before any clock edge.
    #2;
    check("reset occupancy4", 32'(occupancy4), 32'd0);
    check("reset recv_rdy4", 32'(recv_rdy4), 32'd1);
    check("reset send_val4", 32'(send_val4), 32'd0);
    check("reset send_msg4", send_msg4, 32'd0);
    check("reset drop_count4", 32'(drop_count4), 32'd0);
    check("reset drop_count3", 32'(drop_count3), 32'd0);

    @(negedge clk);
    reset = 1'b1;

    // Table-driven portion on the 4-port block.
    for (int i = 0; i < 12; i++) begin
      recv_msg4 = vecs[i].msg;
      recv_val4 = vecs[i].val;
      send_rdy4 = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d send_val", i), 32'(send_val4), 32'(vecs[i].e_sv));
      check($sformatf("vec%0d send_msg", i), send_msg4, vecs[i].e_msg);
      check($sformatf("vec%0d occupancy", i), 32'(occupancy4), 32'(vecs[i].e_occ));
      check($sformatf("vec%0d recv_rdy", i), 32'(recv_rdy4), 32'(vecs[i].e_rdy));
      step();
    end
    recv_val4 = 1'b0;

    // Illegal destination on the 3-port block: 0xC1 (dest 3), then 0x41.
    send_rdy3 = 3'b111;
    recv_msg3 = 8'hC1; recv_val3 = 1'b1;
    step();
    recv_msg3 = 8'h41; recv_val3 = 1'b1;
    check("illegal head send_val", 32'(send_val3), 32'd0);
    check("illegal head send_msg", 32'(send_msg3), 32'd0);
    check("illegal head occupancy", 32'(occupancy3), 32'd1);
    check("illegal head drop_count", 32'(drop_count3), 32'd0);
    step();
    recv_val3 = 1'b0;
    check("after drop drop_count", 32'(drop_count3), 32'd1);
    check("drop+recv occupancy", 32'(occupancy3), 32'd1);
    check("0x41 send_val", 32'(send_val3), 32'b010);
    check("0x41 send_msg", 32'(send_msg3), 32'h00_4100);
    step();
    check("after 0x41 occupancy", 32'(occupancy3), 32'd0);
    check("after 0x41 send_val", 32'(send_val3), 32'd0);

    // Drop counter saturation: 300 more illegal messages, back to back.
    recv_msg3 = 8'hC1;
    recv_val3 = 1'b1;
    for (int k = 0; k < 253; k++) step();
    recv_val3 = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("drop_count 254", 32'(drop_count3), 32'd254);
    check("drain occupancy3", 32'(occupancy3), 32'd0);
    recv_val3 = 1'b1;
    for (int k = 0; k < 47; k++) step();
    recv_val3 = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("drop_count saturated", 32'(drop_count3), 32'd255);
    for (int k = 0; k < 5; k++) step();
    check("drop_count holds", 32'(drop_count3), 32'd255);

    // Streaming: 16 back-to-back messages with cycling destinations.
    send_rdy4 = 4'b1111;
    for (int c = 0; c <= 16; c++) begin
      if (c < 16) begin
        m = {2'(c % 4), 6'(c)};
        recv_msg4 = m;
        recv_val4 = 1'b1;
        check($sformatf("stream%0d recv_rdy", c), 32'(recv_rdy4), 32'd1);
      end else begin
        recv_val4 = 1'b0;
      end
      if (c > 0) begin
        h = exp_q.pop_front();
        exp_sv  = 4'b0001 << h[7:6];
        exp_msg = 32'(h) << (8 * h[7:6]);
        check($sformatf("stream%0d send_val", c), 32'(send_val4), 32'(exp_sv));
        check($sformatf("stream%0d send_msg", c), send_msg4, exp_msg);
      end
      if (c < 16) exp_q.push_back(m);
      step();
    end
    check("stream drained occupancy", 32'(occupancy4), 32'd0);

    // Mid-operation reset with the buffer full.
    send_rdy4 = 4'b0000;
    recv_msg4 = 8'h11; recv_val4 = 1'b1;
    step();
    recv_msg4 = 8'h22;
    step();
    recv_val4 = 1'b0;
    check("pre-reset occupancy", 32'(occupancy4), 32'd2);
    #3;
    reset = 1'b0;
    #1;
    check("async reset occupancy", 32'(occupancy4), 32'd0);
    check("async reset recv_rdy", 32'(recv_rdy4), 32'd1);
    check("async reset send_val", 32'(send_val4), 32'd0);
    check("async reset send_msg", send_msg4, 32'd0);
    check("async reset drop_count3", 32'(drop_count3), 32'd0);
    send_rdy4 = 4'b1111;
    step();
    check("held reset occupancy", 32'(occupancy4), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("post-reset%0d send_val", k), 32'(send_val4), 32'd0);
      check($sformatf("post-reset%0d send_msg", k), send_msg4, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/route_demux_ctrl.md
ROUTE_DEMUX_CTRL -- requirements
Module: route_demux_ctrl

Interface
REQ-001 Parameter p_nbits, default 8: message width in bits; SHALL be >= $clog2(p_noutputs).
REQ-002 Parameter p_noutputs, default 4: number of output ports; SHALL be >= 2 and need not be a power of two.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 recv_msg  input  p_nbits  incoming message; destination field dest = recv_msg[p_nbits-1 -: $clog2(p_noutputs)].
REQ-006 recv_val  input  1  recv_msg is valid.
REQ-007 recv_rdy  output  1  block can accept a message this cycle.
REQ-008 send_msg  output  p_noutputs*p_nbits  flattened per-port message; port i occupies [i*p_nbits +: p_nbits].
REQ-009 send_val  output  p_noutputs  per-port valid.
REQ-010 send_rdy  input  p_noutputs  per-port ready.
REQ-011 drop_count  output  8  count of messages discarded for an illegal destination.
REQ-012 occupancy  output  2  number of buffered messages (0..2).

Function
REQ-013 The block SHALL hold a 2-entry in-order buffer with states EMPTY (0), ONE (1) and FULL (2), reported on occupancy.
REQ-014 A receive transfer SHALL occur in a cycle where recv_val && recv_rdy.
REQ-015 recv_rdy SHALL equal (occupancy != 2), combinationally from state only, with no bypass when FULL.
REQ-016 A send transfer on port i SHALL occur in a cycle where send_val[i] && send_rdy[i].
REQ-017 The head entry's destination is legal when dest < p_noutputs.
REQ-018 For a legal head destination d: send_val SHALL be one-hot at bit d.
REQ-019 For a legal head destination d: send_msg slot d SHALL carry the full head message, including the dest bits.
REQ-020 All send_msg slots other than the selected slot SHALL be zero.
REQ-021 With the buffer EMPTY, send_val SHALL be 0 and send_msg SHALL be all zero.
REQ-022 send_val SHALL depend only on registered state and never on send_rdy; once asserted it SHALL remain asserted with stable send_msg until the transfer occurs.
REQ-023 Minimum latency: a message received in cycle N SHALL be presented on send_val no earlier than cycle N+1, and SHALL be presented in cycle N+1 when the buffer was EMPTY.
REQ-024 The head SHALL dequeue in the same cycle its send transfer occurs.
REQ-025 Sustained throughput SHALL be one message per cycle while the selected port holds send_rdy high.
REQ-026 Illegal head destination: send_val SHALL stay 0 and the head SHALL be discarded after exactly one cycle as head.
REQ-027 When a head is discarded, drop_count SHALL increment by 1, saturating at 255 with no wrap.
REQ-028 Simultaneous receive and dequeue/discard SHALL leave occupancy unchanged.
REQ-029 Message order SHALL be preserved across all ports.
REQ-030 send_rdy on non-selected ports SHALL have no effect.
REQ-031 Contents of buffer entries not currently valid SHALL never be observable on send_msg.

Reset
REQ-032 While reset = 0: occupancy = 0, recv_rdy = 1, send_val = 0, send_msg = 0 and drop_count = 0, asynchronously and independent of clk.
REQ-033 Reset asserted mid-operation SHALL discard all buffered messages; no send transfer SHALL occur after reset assertion.
REQ-034 The first receive transfer SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-035 Basic route: p_nbits=8, p_noutputs=4; send msg 0x85 (dest=2) into an idle block with all send_rdy=1 -> next cycle send_val=4'b0100 and slot 2 = 0x85, other slots 0; occupancy returns to 0.
REQ-036 Backpressure/full: send_rdy=0; push 0x05 (dest 0), 0x46 (dest 1), then 0xC7 (dest 3) -> occupancy reaches 2, recv_rdy=0, 0xC7 is not accepted, send_val=0001 held stable; raise send_rdy[0] -> 0x05 delivered, then 0x46 on port 1, then 0xC7 on port 3, all in order.
REQ-037 Illegal destination: p_noutputs=3, p_nbits=8; send 0xC1 (dest 3) -> send_val stays 0, message discarded after one head cycle, drop_count=1; a following 0x41 is delivered on port 1.
REQ-038 Drop counter saturation: send 300 illegal-destination messages -> drop_count=255 and holds at 255.
REQ-039 Streaming: with all send_rdy=1, send 16 back-to-back messages with cycling destinations -> one delivery per cycle, order preserved, recv_rdy never drops.
REQ-040 Mid-operation reset: with occupancy=2, pull reset low between clock edges -> outputs reach reset values immediately; after release, no stale message appears on send_val.
